// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared types, constants and saturating-increment helper for the UART frame controller
package uart_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, ISSUE} state_t;
  localparam logic [7:0] HEADER_DEF = 8'hA5;
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int w);
    logic [31:0] mx;
    mx = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    return (cnt == mx) ? cnt : cnt + 32'd1;
  endfunction
endpackage

// File: rtl/uart_frame_timer.sv
// uart_frame_timer: tick-driven inter-byte timeout with a one-cycle expire strobe
module uart_frame_timer #(
  parameter int TICKS = 704
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr,
  input  logic en,
  input  logic tick,
  output logic expire
);
  localparam int TW = $clog2(TICKS);
  logic [TW-1:0] cnt;
  logic last;
  always_comb begin
    last = cnt == TW'(TICKS - 1);
    expire = en && tick && last && !clr;
  end
  always_ff @(posedge clk_i)
    if (!rst_ni) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && tick) cnt <= last ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: assembles header/payload/checksum UART frames into commands for the CORDIC
module uart_rx_frame_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int DATA_BYTES = 2,
  parameter logic [7:0] HEADER = HEADER_DEF,
  parameter int TIMEOUT_TICKS = 704,
  parameter int CNT_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    tick_i,
  input  logic [7:0]              rx_byte_i,
  input  logic                    rx_vld_i,
  input  logic                    rx_err_i,
  output logic [8*DATA_BYTES-1:0] cmd_data_o,
  output logic                    cmd_vld_o,
  input  logic                    cmd_rdy_i,
  output logic                    busy_o,
  output logic [CNT_W-1:0]        par_err_cnt_o,
  output logic [CNT_W-1:0]        frm_err_cnt_o,
  output logic [CNT_W-1:0]        ovr_cnt_o
);
  localparam int PW = 8 * DATA_BYTES;
  localparam int IW = $clog2(DATA_BYTES + 1);
  state_t state;
  logic [IW-1:0] idx;
  logic [7:0] acc;
  logic [PW-1:0] shreg;
  logic in_frame, expire;
  assign in_frame = state == PAYLOAD || state == CHECK;
  assign busy_o = state != IDLE;
  // a received byte restarts the inter-byte window and always beats a coincident tick
  uart_frame_timer #(.TICKS(TIMEOUT_TICKS)) u_timer (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .clr(rx_vld_i || !in_frame),
    .en(in_frame),
    .tick(tick_i),
    .expire(expire)
  );
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      state <= IDLE;
      idx <= '0;
      acc <= '0;
      shreg <= '0;
      cmd_data_o <= '0;
      cmd_vld_o <= 1'b0;
      par_err_cnt_o <= '0;
      frm_err_cnt_o <= '0;
      ovr_cnt_o <= '0;
    end else begin
      if (rx_err_i) par_err_cnt_o <= CNT_W'(sat_inc(32'(par_err_cnt_o), CNT_W));
      case (state)
        IDLE:
          if (rx_vld_i && rx_byte_i == HEADER) begin
            state <= PAYLOAD;
            idx <= '0;
            acc <= '0;
          end
        PAYLOAD, CHECK:
          if (rx_err_i || expire) begin
            frm_err_cnt_o <= CNT_W'(sat_inc(32'(frm_err_cnt_o), CNT_W));
            state <= IDLE;
          end else if (rx_vld_i && state == PAYLOAD) begin
            shreg <= PW'({shreg, rx_byte_i});
            acc <= acc ^ rx_byte_i;
            idx <= idx + 1'b1;
            if (idx == IW'(DATA_BYTES - 1)) state <= CHECK;
          end else if (rx_vld_i) begin
            if (rx_byte_i == acc) begin
              state <= ISSUE;
              cmd_vld_o <= 1'b1;
              cmd_data_o <= shreg;
            end else begin
              frm_err_cnt_o <= CNT_W'(sat_inc(32'(frm_err_cnt_o), CNT_W));
              state <= IDLE;
            end
          end
        ISSUE: begin
          if (rx_vld_i || rx_err_i) ovr_cnt_o <= CNT_W'(sat_inc(32'(ovr_cnt_o), CNT_W));
          if (cmd_rdy_i) begin
            state <= IDLE;
            cmd_vld_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed self-checking bench for the UART frame controller
module tb_uart_rx_frame_ctrl;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic tick_i = 1'b0;
  logic [7:0] rx_byte_i = 8'h00;
  logic rx_vld_i = 1'b0;
  logic rx_err_i = 1'b0;
  logic [15:0] cmd_data_o;
  logic cmd_vld_o;
  logic cmd_rdy_i = 1'b1;
  logic busy_o;
  logic [7:0] par_err_cnt_o, frm_err_cnt_o, ovr_cnt_o;
  int total = 0;
  int bad = 0;

  uart_rx_frame_ctrl dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .tick_i(tick_i),
    .rx_byte_i(rx_byte_i),
    .rx_vld_i(rx_vld_i),
    .rx_err_i(rx_err_i),
    .cmd_data_o(cmd_data_o),
    .cmd_vld_o(cmd_vld_o),
    .cmd_rdy_i(cmd_rdy_i),
    .busy_o(busy_o),
    .par_err_cnt_o(par_err_cnt_o),
    .frm_err_cnt_o(frm_err_cnt_o),
    .ovr_cnt_o(ovr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte_i = b;
    rx_vld_i = 1'b1;
    step();
    rx_vld_i = 1'b0;
  endtask

  task automatic perr();
    rx_err_i = 1'b1;
    step();
    rx_err_i = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_vld", 32'(cmd_vld_o), 0);
    chk("rst_data", 32'(cmd_data_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_cnts", {8'h0, par_err_cnt_o, frm_err_cnt_o, ovr_cnt_o}, 0);
    rst_ni = 1'b1;
    step();
    send(8'h12);
    chk("idle_ignore", 32'(busy_o), 0);
    // good frame, ready already high
    send(8'hA5);
    send(8'h12);
    send(8'h34);
    chk("t1_busy", 32'(busy_o), 1);
    chk("t1_novld", 32'(cmd_vld_o), 0);
    send(8'h26);
    chk("t1_vld", 32'(cmd_vld_o), 1);
    chk("t1_data", 32'(cmd_data_o), 32'h1234);
    step();
    chk("t1_drop", 32'(cmd_vld_o), 0);
    chk("t1_idle", 32'(busy_o), 0);
    chk("t1_cnts", {8'h0, par_err_cnt_o, frm_err_cnt_o, ovr_cnt_o}, 0);
    // bad checksum
    send(8'hA5);
    send(8'h12);
    send(8'h34);
    send(8'h27);
    chk("t2_vld", 32'(cmd_vld_o), 0);
    chk("t2_frm", 32'(frm_err_cnt_o), 1);
    chk("t2_busy", 32'(busy_o), 0);
    chk("t2_hold", 32'(cmd_data_o), 32'h1234);
    // inter-byte timeout
    send(8'hA5);
    send(8'h12);
    tick_i = 1'b1;
    repeat (703) step();
    chk("t3_pre", 32'(busy_o), 1);
    step();
    tick_i = 1'b0;
    chk("t3_busy", 32'(busy_o), 0);
    chk("t3_frm", 32'(frm_err_cnt_o), 2);
    send(8'hA5);
    send(8'hAB);
    send(8'hCD);
    send(8'h66);
    chk("t3_vld", 32'(cmd_vld_o), 1);
    chk("t3_data", 32'(cmd_data_o), 32'hABCD);
    step();
    // header value inside payload is data
    send(8'hA5);
    send(8'hA5);
    send(8'h12);
    send(8'hB7);
    chk("hdr_vld", 32'(cmd_vld_o), 1);
    chk("hdr_data", 32'(cmd_data_o), 32'hA512);
    step();
    // backpressure with bytes dropped in ISSUE
    cmd_rdy_i = 1'b0;
    send(8'hA5);
    send(8'h12);
    send(8'h34);
    send(8'h26);
    for (int i = 0; i < 20; i++) begin
      rx_byte_i = 8'(i);
      rx_vld_i = (i == 3 || i == 8 || i == 13);
      step();
      rx_vld_i = 1'b0;
      chk("t4_vld", 32'(cmd_vld_o), 1);
      chk("t4_data", 32'(cmd_data_o), 32'h1234);
    end
    chk("t4_ovr", 32'(ovr_cnt_o), 3);
    cmd_rdy_i = 1'b1;
    step();
    chk("t4_done", 32'(cmd_vld_o), 0);
    chk("t4_idle", 32'(busy_o), 0);
    // parity error while issuing
    cmd_rdy_i = 1'b0;
    send(8'hA5);
    send(8'h12);
    send(8'h34);
    send(8'h26);
    perr();
    chk("iss_ovr", 32'(ovr_cnt_o), 4);
    chk("iss_par", 32'(par_err_cnt_o), 1);
    chk("iss_vld", 32'(cmd_vld_o), 1);
    cmd_rdy_i = 1'b1;
    step();
    chk("iss_done", 32'(cmd_vld_o), 0);
    // in-frame parity abort, then saturation
    send(8'hA5);
    perr();
    chk("t5_par", 32'(par_err_cnt_o), 2);
    chk("t5_frm", 32'(frm_err_cnt_o), 3);
    chk("t5_busy", 32'(busy_o), 0);
    repeat (300) perr();
    chk("t5_sat", 32'(par_err_cnt_o), 255);
    chk("t5_frm2", 32'(frm_err_cnt_o), 3);
    // reset while in CHECK
    send(8'hA5);
    send(8'h12);
    send(8'h34);
    chk("t6_busy", 32'(busy_o), 1);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    chk("t6_rst_busy", 32'(busy_o), 0);
    chk("t6_rst_out", {15'h0, cmd_vld_o, cmd_data_o}, 0);
    chk("t6_rst_cnts", {8'h0, par_err_cnt_o, frm_err_cnt_o, ovr_cnt_o}, 0);
    send(8'h26);
    chk("t6_vld", 32'(cmd_vld_o), 0);
    chk("t6_idle", 32'(busy_o), 0);
    step();
    chk("t6_vld2", 32'(cmd_vld_o), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Sequences received UART bytes into fixed-length command frames for the CORDIC datapath.
- Sits between uart_rx (byte / valid / parity-error strobes) and the CORDIC input valid/ready port.
- Frame format: header byte, DATA_BYTES payload bytes (MSB first), then a checksum byte equal to the XOR of the payload bytes.
- Also enforces an inter-byte timeout and keeps saturating error counters.

Parameters:
- DATA_BYTES, 2, payload bytes per frame (1..4).
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_TICKS, 704, oversample ticks allowed between bytes inside a frame (4 character times at 16x, 11-bit frames).
- CNT_W, 8, width of each error counter.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  synchronous reset, active-low.
- tick_i  in  1  oversample tick strobe, same source as uart_rx.
- rx_byte_i  in  8  received data byte.
- rx_vld_i  in  1  one-cycle strobe: rx_byte_i valid, parity OK.
- rx_err_i  in  1  one-cycle strobe: byte received with parity error. Never coincident with rx_vld_i.
- cmd_data_o  out  8*DATA_BYTES  assembled payload, first byte in MSBs.
- cmd_vld_o  out  1  command valid to CORDIC.
- cmd_rdy_i  in  1  CORDIC ready.
- busy_o  out  1  high in any state other than IDLE.
- par_err_cnt_o  out  CNT_W  parity-error count, saturating.
- frm_err_cnt_o  out  CNT_W  framing error count (bad checksum, timeout, in-frame parity abort), saturating.
- ovr_cnt_o  out  CNT_W  count of bytes dropped while in ISSUE, saturating.

Behaviour:
- Reset (rst_ni low at a clk_i edge): state IDLE; cmd_vld_o=0; cmd_data_o=0; all counters=0; timer=0; byte index=0. Reset mid-frame or mid-ISSUE discards everything with no output.
- States: IDLE, PAYLOAD, CHECK, ISSUE.
- IDLE:
  - rx_vld_i with rx_byte_i==HEADER: go to PAYLOAD, index=0, timer=0, checksum accumulator=0.
  - Any other byte is ignored.
  - rx_err_i: par_err_cnt +1 only.
- PAYLOAD:
  - rx_vld_i: shift the byte into the payload register, acc ^= byte, timer=0, index+1.
  - When index reaches DATA_BYTES-1 (the last payload byte is accepted), go to CHECK.
  - A HEADER value received here is treated as payload data.
- CHECK, on rx_vld_i:
  - byte==acc: go to ISSUE. cmd_vld_o rises on the next clk_i edge; latency from the checksum strobe is 1 cycle.
  - Mismatch: frm_err_cnt +1, go to IDLE.
- PAYLOAD/CHECK common rules:
  - rx_err_i: par_err_cnt +1, frm_err_cnt +1, go to IDLE.
  - Timer increments on tick_i.
  - Timer reaching TIMEOUT_TICKS-1 with tick_i: frm_err_cnt +1, go to IDLE.
  - rx_vld_i coincident with tick_i: the byte wins and the timer clears.
- ISSUE:
  - cmd_vld_o=1 and cmd_data_o stable until cmd_vld_o && cmd_rdy_i. On that cycle, go to IDLE and cmd_vld_o drops on the next edge.
  - Any rx_vld_i/rx_err_i arriving in ISSUE: ovr_cnt +1 and the byte is discarded. rx_err_i also increments par_err_cnt. No timeout in ISSUE.
  - cmd_rdy_i held high before cmd_vld_o: transfer completes on the first valid cycle, so ISSUE lasts exactly 1 cycle.
- cmd_data_o updates only on entry to ISSUE. It holds the last command otherwise.
- Counters saturate at 2^CNT_W-1 and never wrap. Two increments of the same counter in one cycle cannot occur.
- Timer width: $clog2(TIMEOUT_TICKS).
- Index width: $clog2(DATA_BYTES+1).

Decomposition:
- Package uart_ctrl_pkg holds:
  - state_t enum (IDLE, PAYLOAD, CHECK, ISSUE);
  - the HEADER default constant;
  - function sat_inc(cnt) for the saturating counters.
- One natural sub-module, uart_frame_timer: a tick-driven timeout counter with inputs clr, en, tick and a one-cycle expire output.

Test Plan:
- Bytes A5,12,34,26 each with rx_vld_i, cmd_rdy_i=1 -> cmd_vld_o high exactly 1 cycle after the 26 strobe, cmd_data_o=16'h1234, counters all 0.
- Same frame with checksum 27 -> no cmd_vld_o, frm_err_cnt_o=1, busy_o=0 afterwards.
- A5,12, then 704 ticks with no byte -> returns to IDLE, frm_err_cnt_o=1. A following A5,AB,CD,66 -> cmd_data_o=16'hABCD.
- Valid frame with cmd_rdy_i=0 for 20 cycles while 3 bytes arrive -> cmd_vld_o and cmd_data_o held constant, ovr_cnt_o=3, transfer completes when cmd_rdy_i rises.
- A5, then rx_err_i -> par_err_cnt_o=1, frm_err_cnt_o=1, IDLE. Then 300 rx_err_i strobes in IDLE -> par_err_cnt_o saturates at 255.
- rst_ni low for 1 cycle while in CHECK -> all outputs 0, state IDLE. The trailing checksum byte alone produces no command.
